// File: rtl/de_pkg.sv
// Shared decode-stage scoreboard constants: register file geometry and
// pending-write counter sizing.
package de_pkg;

  localparam int DE_NREGS     = 32;
  localparam int DE_REGNOBITS = 5;
  localparam int DE_CNTBITS   = 2;
  localparam int DE_NSRC      = 2;
  localparam int DE_NWB       = 2;

  // Largest value a pending-write counter of the given width can hold.
  function automatic int cnt_max(input int bits);
    return (1 << bits) - 1;
  endfunction

  localparam int DE_CNT_MAX = (1 << DE_CNTBITS) - 1;

endpackage

// File: rtl/sb_counter.sv
// One pending-write counter: increments on alloc, decrements by the number of
// same-cycle releases, clamps at 0 (flagging underflow) and at its maximum.
module sb_counter
  import de_pkg::*;
#(
  parameter int CNTBITS = DE_CNTBITS,
  parameter int DECBITS = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic [DECBITS-1:0] dec_count,
  output logic [CNTBITS-1:0] count,
  output logic [CNTBITS-1:0] count_nxt,
  output logic               underflow
);

  localparam int W = ((CNTBITS > DECBITS) ? CNTBITS : DECBITS) + 1;
  localparam logic [W-1:0] MAX_W = W'(cnt_max(CNTBITS));

  logic [CNTBITS-1:0] count_r;
  logic [W-1:0]       up_s;
  logic [W-1:0]       dec_s;
  logic [W-1:0]       diff_s;
  logic [CNTBITS-1:0] nxt_s;
  logic               uflow_s;

  // Net alloc/release effect, widened so the clamp tests see the true result.
  always_comb begin
    up_s    = W'(count_r) + W'(inc);
    dec_s   = W'(dec_count);
    diff_s  = up_s - dec_s;
    nxt_s   = count_r;
    uflow_s = 1'b0;
    if (up_s < dec_s) begin
      nxt_s   = {CNTBITS{1'b0}};
      uflow_s = 1'b1;
    end else if (diff_s > MAX_W) begin
      nxt_s   = MAX_W[CNTBITS-1:0];
      uflow_s = 1'b0;
    end else begin
      nxt_s   = diff_s[CNTBITS-1:0];
      uflow_s = 1'b0;
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {CNTBITS{1'b0}};
    end else begin
      count_r <= nxt_s;
    end
  end

  assign count     = count_r;
  assign count_nxt = nxt_s;
  assign underflow = uflow_s;

endmodule

// File: rtl/de_scoreboard.sv
// Decode-stage register scoreboard: per-register pending-write counters,
// RAW/saturation stall generation and stall statistics.
module de_scoreboard
  import de_pkg::*;
#(
  parameter int NREGS     = DE_NREGS,
  parameter int REGNOBITS = DE_REGNOBITS,
  parameter int NSRC      = DE_NSRC,
  parameter int NWB       = DE_NWB,
  parameter int CNTBITS   = DE_CNTBITS,
  parameter int BYPASS_WB = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alloc_valid,
  input  logic [REGNOBITS-1:0]      alloc_rd,
  input  logic [NSRC-1:0]           src_valid,
  input  logic [NSRC*REGNOBITS-1:0] src_regno,
  input  logic [NWB-1:0]            rel_valid,
  input  logic [NWB*REGNOBITS-1:0]  rel_regno,
  input  logic                      ext_stall,
  output logic                      stall,
  output logic [NREGS-1:0]          busy_vec,
  output logic [31:0]               stall_cycles,
  output logic                      underflow
);

  localparam int RELBITS = $clog2(NWB + 1);
  localparam logic [CNTBITS-1:0] CNT_MAX = CNTBITS'(cnt_max(CNTBITS));

  logic [CNTBITS-1:0]   count_s     [NREGS];
  logic [CNTBITS-1:0]   count_nxt_s [NREGS];
  logic [RELBITS-1:0]   rel_cnt_s   [NREGS];
  logic [REGNOBITS-1:0] src_reg_s   [NSRC];
  logic [NREGS-1:0]     uflow_s;
  logic [NREGS-1:0]     inc_s;
  logic [NSRC-1:0]      hazard_s;
  logic                 sat_s;
  logic                 stall_s;
  logic                 alloc_fire_s;
  logic [NREGS-1:0]     busy_vec_r;
  logic [31:0]          stall_cycles_r;
  logic                 underflow_r;

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    assign src_reg_s[s] = src_regno[s*REGNOBITS +: REGNOBITS];
  end

  // Number of release ports naming each register this cycle; reg 0 never counts.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      rel_cnt_s[r] = {RELBITS{1'b0}};
      for (int p = 0; p < NWB; p++) begin
        if (r != 0 && rel_valid[p] && rel_regno[p*REGNOBITS +: REGNOBITS] == REGNOBITS'(r)) begin
          rel_cnt_s[r] = rel_cnt_s[r] + RELBITS'(1);
        end else begin
          rel_cnt_s[r] = rel_cnt_s[r];
        end
      end
    end
  end

  // RAW hazards, counter saturation and the resulting DE stall.
  always_comb begin
    hazard_s = {NSRC{1'b0}};
    for (int s = 0; s < NSRC; s++) begin
      if (src_valid[s] && src_reg_s[s] != {REGNOBITS{1'b0}} &&
          count_s[src_reg_s[s]] != {CNTBITS{1'b0}}) begin
        // Writes retiring this cycle reach the RF on the negedge, so they can be read.
        if (BYPASS_WB != 0 &&
            32'(count_s[src_reg_s[s]]) == 32'(rel_cnt_s[src_reg_s[s]]) &&
            !(alloc_valid && alloc_rd == src_reg_s[s])) begin
          hazard_s[s] = 1'b0;
        end else begin
          hazard_s[s] = 1'b1;
        end
      end else begin
        hazard_s[s] = 1'b0;
      end
    end
    sat_s        = alloc_valid && (alloc_rd != {REGNOBITS{1'b0}}) && (count_s[alloc_rd] == CNT_MAX);
    stall_s      = (|hazard_s) || sat_s || ext_stall;
    alloc_fire_s = alloc_valid && (alloc_rd != {REGNOBITS{1'b0}}) && !stall_s;
    for (int r = 0; r < NREGS; r++) begin
      inc_s[r] = alloc_fire_s && (alloc_rd == REGNOBITS'(r));
    end
  end

  assign count_s[0]     = {CNTBITS{1'b0}};
  assign count_nxt_s[0] = {CNTBITS{1'b0}};
  assign uflow_s[0]     = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_cnt
    sb_counter #(
      .CNTBITS (CNTBITS),
      .DECBITS (RELBITS)
    ) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc       (inc_s[r]),
      .dec_count (rel_cnt_s[r]),
      .count     (count_s[r]),
      .count_nxt (count_nxt_s[r]),
      .underflow (uflow_s[r])
    );
  end

  // Busy view, stall statistics and sticky underflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_vec_r     <= {NREGS{1'b0}};
      stall_cycles_r <= 32'h0000_0000;
      underflow_r    <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        busy_vec_r[r] <= (count_nxt_s[r] != {CNTBITS{1'b0}});
      end
      if (stall_s && stall_cycles_r != 32'hFFFF_FFFF) begin
        stall_cycles_r <= stall_cycles_r + 32'd1;
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
      underflow_r <= underflow_r | (|uflow_s);
    end
  end

  assign stall        = stall_s;
  assign busy_vec     = busy_vec_r;
  assign stall_cycles = stall_cycles_r;
  assign underflow    = underflow_r;

endmodule

// File: tb/tb_de_scoreboard.sv
// Directed plus randomized bench for de_scoreboard against an array-based
// model of per-register pending-write counts.
module tb_de_scoreboard;

  localparam int NREGS = 32;
  localparam int RB    = 5;
  localparam int CMAX  = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            alloc_valid;
  logic [RB-1:0]   alloc_rd;
  logic [1:0]      src_valid;
  logic [2*RB-1:0] src_regno;
  logic [1:0]      rel_valid;
  logic [2*RB-1:0] rel_regno;
  logic            ext_stall;
  logic            stall;
  logic [31:0]     busy_vec;
  logic [31:0]     stall_cycles;
  logic            underflow;

  int total = 0;
  int bad   = 0;

  int  m_cnt [NREGS];
  bit  m_uf;
  int  m_sc;

  always #5 clk = ~clk;

  de_scoreboard #(
    .NREGS(32), .REGNOBITS(5), .NSRC(2), .NWB(2), .CNTBITS(2), .BYPASS_WB(1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_valid  (alloc_valid),
    .alloc_rd     (alloc_rd),
    .src_valid    (src_valid),
    .src_regno    (src_regno),
    .rel_valid    (rel_valid),
    .rel_regno    (rel_regno),
    .ext_stall    (ext_stall),
    .stall        (stall),
    .busy_vec     (busy_vec),
    .stall_cycles (stall_cycles),
    .underflow    (underflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) m_cnt[r] = 0;
    m_uf = 1'b0;
    m_sc = 0;
  endtask

  function automatic logic [31:0] m_busy();
    logic [31:0] v;
    for (int r = 0; r < NREGS; r++) v[r] = (m_cnt[r] != 0);
    return v;
  endfunction

  // One clock of stimulus: check stall live, then the registered outputs after the edge.
  task automatic step(input bit av, input int ard, input bit [1:0] sv, input int s0, input int s1,
                      input bit [1:0] rv, input int r0, input int r1, input bit ext, input string tag);
    int  nrel [NREGS];
    int  srcs [2];
    bit  exp_stall;
    bit  fire;
    int  v;
    alloc_valid = av;  alloc_rd  = RB'(ard);
    src_valid   = sv;  src_regno = {RB'(s1), RB'(s0)};
    rel_valid   = rv;  rel_regno = {RB'(r1), RB'(r0)};
    ext_stall   = ext;
    for (int r = 0; r < NREGS; r++) nrel[r] = 0;
    if (rv[0] && r0 != 0) nrel[r0]++;
    if (rv[1] && r1 != 0) nrel[r1]++;
    srcs[0] = s0;
    srcs[1] = s1;
    exp_stall = ext;
    for (int s = 0; s < 2; s++) begin
      if (sv[s] && srcs[s] != 0 && m_cnt[srcs[s]] > 0 &&
          !(m_cnt[srcs[s]] == nrel[srcs[s]] && !(av && ard == srcs[s])))
        exp_stall = 1'b1;
    end
    if (av && ard != 0 && m_cnt[ard] == CMAX) exp_stall = 1'b1;
    #1;
    chk({tag, ".stall"}, 64'(stall), 64'(exp_stall));
    @(posedge clk);
    fire = av && ard != 0 && !exp_stall;
    for (int r = 1; r < NREGS; r++) begin
      v = m_cnt[r] + ((fire && ard == r) ? 1 : 0) - nrel[r];
      if (v < 0) begin v = 0; m_uf = 1'b1; end
      if (v > CMAX) v = CMAX;
      m_cnt[r] = v;
    end
    if (exp_stall && m_sc != 32'hFFFF_FFFF) m_sc++;
    @(negedge clk);
    chk({tag, ".busy"}, 64'(busy_vec), 64'(m_busy()));
    chk({tag, ".sc"}, 64'(stall_cycles), 64'(m_sc));
    chk({tag, ".uf"}, 64'(underflow), 64'(m_uf));
  endtask

  initial begin
    reset = 1'b0;
    alloc_valid = 1'b0; alloc_rd = '0; src_valid = '0; src_regno = '0;
    rel_valid = '0; rel_regno = '0; ext_stall = 1'b0;
    model_reset();
    #2;
    chk("rst.busy", 64'(busy_vec), 64'd0);
    chk("rst.sc", 64'(stall_cycles), 64'd0);
    chk("rst.uf", 64'(underflow), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Alloc then RAW hazard, then release with bypass.
    step(1, 5, 2'b00, 0, 0, 2'b00, 0, 0, 0, "t1a");
    step(0, 0, 2'b01, 5, 0, 2'b00, 0, 0, 0, "t1b");
    chk("t1.busy5", 64'(busy_vec[5]), 64'd1);
    chk("t1.sc", 64'(stall_cycles), 64'd1);
    step(0, 0, 2'b01, 5, 0, 2'b01, 5, 0, 0, "t2");
    // Saturation on reg 7.
    step(1, 7, 2'b00, 0, 0, 2'b00, 0, 0, 0, "t3a");
    step(1, 7, 2'b00, 0, 0, 2'b00, 0, 0, 0, "t3b");
    step(1, 7, 2'b00, 0, 0, 2'b00, 0, 0, 0, "t3c");
    step(1, 7, 2'b00, 0, 0, 2'b00, 0, 0, 0, "t3d");
    step(0, 0, 2'b00, 0, 0, 2'b01, 7, 0, 0, "t3e");
    step(1, 7, 2'b00, 0, 0, 2'b00, 0, 0, 0, "t3f");
    // Double release of 7 on both ports in one cycle.
    step(0, 0, 2'b00, 0, 0, 2'b11, 7, 7, 0, "t3g");
    // Alloc and release of reg 3 in the same cycle.
    step(1, 3, 2'b00, 0, 0, 2'b00, 0, 0, 0, "t4a");
    step(1, 3, 2'b00, 0, 0, 2'b01, 3, 0, 0, "t4b");
    chk("t4.busy3", 64'(busy_vec[3]), 64'd1);
    // Underflow, reg 0 handling, external stall.
    step(0, 0, 2'b00, 0, 0, 2'b10, 0, 9, 0, "t5a");
    chk("t5.uf", 64'(underflow), 64'd1);
    step(1, 0, 2'b11, 0, 0, 2'b01, 0, 0, 0, "t5b");
    step(1, 12, 2'b00, 0, 0, 2'b00, 0, 0, 1, "t5c");
    // Async reset mid-stream.
    step(1, 4, 2'b00, 0, 0, 2'b00, 0, 0, 0, "t6a");
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("t6.busy", 64'(busy_vec), 64'd0);
    chk("t6.sc", 64'(stall_cycles), 64'd0);
    chk("t6.uf", 64'(underflow), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, 2'b01, 4, 0, 2'b00, 0, 0, 0, "t6b");

    // Random traffic over a small register window to provoke hazards and races.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 2) != 0), int'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           ($urandom_range(0, 9) == 0), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
